sine_period_meter: RTL
======================

Name: sine_period_meter

Overview:
- Receive-side measurement block for the signed 8-bit waveform stream produced by the sample generators. Consumes one sample per accepted `sample_valid`.
- Detects rising zero crossings and reports, once per cycle of the waveform:
  - period in samples
  - peak (most positive) sample
  - trough (most negative) sample
- Used as the on-chip loopback checker for the function generator output path.

Parameters:
- PERIOD_W, 16, width of the period counter and the `period` output.
- HYST, 8'sd16, hysteresis threshold magnitude. Used only when SINE_METER_HYST_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: returns to IDLE and clears `timeout`.
- sample_valid  in  1  `sample` is accepted this cycle.
- sample  in  8  signed two's-complement waveform sample.
- meas_valid  out  1  one-cycle pulse: `period`/`peak`/`trough` updated.
- period  out  PERIOD_W  samples per waveform cycle.
- peak  out  8  signed maximum over the last measured cycle.
- trough  out  8  signed minimum over the last measured cycle.
- locked  out  1  at least one measurement has completed since the last reset/clear/timeout.
- timeout  out  1  sticky: no crossing within 2^PERIOD_W-1 samples.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs are 0; state is IDLE; `armed` is 0.
  - internal counter `cnt`=0, `max_r`=-128, `min_r`=+127.
- Accepted sample: `sample_valid`=1 and `clear`=0. All state holds on cycles without an accepted sample.
- Arming: `armed` is set by any accepted sample < 0.
- Rising crossing: an accepted sample >= 0 while `armed`=1. Consumes `armed` (cleared in the same cycle).
- States:
  - IDLE: wait for a crossing. On a crossing:
    - `cnt`=1, `max_r`=`min_r`=sample
    - go to MEASURE.
  - MEASURE, each accepted non-crossing sample:
    - `cnt`+=1
    - `max_r`=max(`max_r`,sample), `min_r`=min(`min_r`,sample), compared as signed.
  - MEASURE, on a crossing:
    - Register `period`=`cnt`, `peak`=`max_r`, `trough`=`min_r`. The crossing sample itself is excluded from these results.
    - Pulse `meas_valid` for one cycle; `locked` goes to 1.
    - Restart the window: `cnt`=1, `max_r`=`min_r`=sample. Stay in MEASURE.
- Latency: a crossing sample accepted in cycle N gives `meas_valid`=1 and new outputs visible in cycle N+1.
- Outputs hold between pulses.
- Period window: the crossing sample is counted as the first sample of the new window.
- Counter wrap:
  - `cnt` never wraps.
  - If `cnt` = 2^PERIOD_W-1 and a non-crossing sample is accepted:
    - `timeout`=1 (sticky), `locked`=0
    - go to IDLE; `armed` keeps its value
    - no `meas_valid` pulse.
- `clear`:
  - Forces IDLE, `armed`=0, `cnt`=0, `locked`=0, `timeout`=0.
  - `period`/`peak`/`trough` keep their last values.
  - `clear` with `sample_valid` in the same cycle: `clear` wins and the sample is discarded.
- Minimum reportable period is 2, since an arming negative sample is required between crossings.
- Signed rules: all comparisons are signed 8-bit. `sample` = 0 counts as non-negative.

Optional Feature:
- Macro: SINE_METER_HYST_EN.
- Defined:
  - `armed` is set only by an accepted sample <= -HYST.
  - A crossing requires an accepted sample >= +HYST while `armed`.
  - Noise near zero produces no spurious crossings.
  - Period semantics are otherwise unchanged.
- Undefined: arming threshold is <0 and crossing threshold is >=0, as above. HYST is unused.

Test Plan:
- Repeated 8-sample stream 00,5A,7F,5A,00,A6,81,A6 with `sample_valid`=1:
  - first `meas_valid` one cycle after the second 00 at index 8 crossing (index 16)
  - results: `period`=8, `peak`=0x7F, `trough`=0x81
  - `locked`=1; pulses then repeat every 8 cycles.
- Same stream with `sample_valid` toggled 1/0 each cycle:
  - `period`=8, `peak`/`trough` unchanged
  - pulses every 16 clocks.
- 16-slice stream (00,38,5A,73,7F,73,5A,38,00,C8,A6,8D,81,8D,A6,C8):
  - `period`=16, `peak`=0x7F, `trough`=0x81.
- PERIOD_W=4; constant +0x10 after one crossing:
  - `timeout`=1 and `locked`=0 after 15 samples, no pulse
  - then `clear` → `timeout`=0.
- Assert `clear` in the same cycle as a crossing sample:
  - no `meas_valid`; state IDLE; outputs keep their prior values.
- Drop rst_n mid-MEASURE asynchronously:
  - all outputs 0 immediately
  - the 8-sample stream re-locks with `period`=8 on the second crossing after release.
- SINE_METER_HYST_EN with HYST=16, stream …,F8,08,F8,08,… (±8) superimposed on a 0x81/0x7F square of period 20:
  - only `period`=20 is reported.

Source files
------------

// File: rtl/sine_period_meter.sv
// Measures period, peak and trough of a signed 8-bit waveform between rising zero crossings.
// Define SINE_METER_HYST_EN to require +/-HYST excursions for arming and crossing.
module sine_period_meter #(
    parameter int unsigned       PERIOD_W = 16,
    parameter logic signed [7:0] HYST     = 8'sd16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       sample_valid,
    input  logic signed [7:0]          sample,
    output logic                       meas_valid,
    output logic [PERIOD_W-1:0]        period,
    output logic signed [7:0]          peak,
    output logic signed [7:0]          trough,
    output logic                       locked,
    output logic                       timeout
);

`ifdef SINE_METER_HYST_EN
    localparam logic signed [7:0] ARM_LIM   = -HYST;
    localparam logic signed [7:0] CROSS_LIM = HYST;
`else
    // Plain zero-crossing thresholds; HYST is masked out so it has no effect here
    localparam logic signed [7:0] ARM_LIM   = -8'sd1;
    localparam logic signed [7:0] CROSS_LIM = HYST & 8'sd0;
`endif

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                    r_state, w_state_next;
    logic                      r_armed, w_armed_next;
    logic [PERIOD_W-1:0]       r_cnt, w_cnt_next;
    logic signed [7:0]         r_max, w_max_next;
    logic signed [7:0]         r_min, w_min_next;
    logic                      r_meas_valid, w_meas_valid_next;
    logic [PERIOD_W-1:0]       r_period, w_period_next;
    logic signed [7:0]         r_peak, w_peak_next;
    logic signed [7:0]         r_trough, w_trough_next;
    logic                      r_locked, w_locked_next;
    logic                      r_timeout, w_timeout_next;

    logic w_accept;
    logic w_arm;
    logic w_cross;

    assign w_accept = sample_valid && !clear;
    assign w_arm    = w_accept && (sample <= ARM_LIM);
    assign w_cross  = w_accept && r_armed && (sample >= CROSS_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_armed      <= 1'b0;
            r_cnt        <= '0;
            r_max        <= -8'sd128;
            r_min        <= 8'sd127;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_peak       <= '0;
            r_trough     <= '0;
            r_locked     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_armed      <= w_armed_next;
            r_cnt        <= w_cnt_next;
            r_max        <= w_max_next;
            r_min        <= w_min_next;
            r_meas_valid <= w_meas_valid_next;
            r_period     <= w_period_next;
            r_peak       <= w_peak_next;
            r_trough     <= w_trough_next;
            r_locked     <= w_locked_next;
            r_timeout    <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_armed_next      = r_armed;
        w_cnt_next        = r_cnt;
        w_max_next        = r_max;
        w_min_next        = r_min;
        w_meas_valid_next = 1'b0;
        w_period_next     = r_period;
        w_peak_next       = r_peak;
        w_trough_next     = r_trough;
        w_locked_next     = r_locked;
        w_timeout_next    = r_timeout;

        if (clear) begin
            w_state_next   = ST_IDLE;
            w_armed_next   = 1'b0;
            w_cnt_next     = '0;
            w_locked_next  = 1'b0;
            w_timeout_next = 1'b0;
        end else if (w_accept) begin
            if (w_arm) begin
                w_armed_next = 1'b1;
            end else if (w_cross) begin
                w_armed_next = 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cross) begin
                        w_cnt_next   = PERIOD_W'(1);
                        w_max_next   = sample;
                        w_min_next   = sample;
                        w_state_next = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_cross) begin
                        // The crossing sample opens the next window, not the finished one
                        w_period_next     = r_cnt;
                        w_peak_next       = r_max;
                        w_trough_next     = r_min;
                        w_meas_valid_next = 1'b1;
                        w_locked_next     = 1'b1;
                        w_cnt_next        = PERIOD_W'(1);
                        w_max_next        = sample;
                        w_min_next        = sample;
                    end else if (r_cnt == CNT_MAX) begin
                        w_timeout_next = 1'b1;
                        w_locked_next  = 1'b0;
                        w_cnt_next     = '0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + PERIOD_W'(1);
                        if (sample > r_max) begin
                            w_max_next = sample;
                        end
                        if (sample < r_min) begin
                            w_min_next = sample;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign meas_valid = r_meas_valid;
    assign period     = r_period;
    assign peak       = r_peak;
    assign trough     = r_trough;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule
